// File: rtl/add_sat_pipe_if.sv
// +----------------------------------------------------------------------+
// | add_sat_pipe_if : operand/result handshake bundle for add_sat_pipe   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface add_sat_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int NSEG = WIDTH / 8;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sat;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             co;
  logic [NSEG-1:0]  satf;

  modport master (
    output in_valid, a, b, cin, sat, mode, out_ready,
    input  in_ready, out_valid, r, co, satf
  );

  modport slave (
    input  in_valid, a, b, cin, sat, mode, out_ready,
    output in_ready, out_valid, r, co, satf
  );
endinterface

`default_nettype wire

// File: rtl/add_sat_pipe.sv
// +----------------------------------------------------------------------+
// | add_sat_pipe : 2-stage SIMD (8/16/full) unsigned+signed-delta adder  |
// | with per-lane saturation and a saturation event counter.             |
// | Optional sat_sticky output: define ADD_SAT_PIPE_STICKY_EN.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module add_sat_pipe #(
  parameter int WIDTH = 32
) (
  input  logic         sys_clk,
  input  logic         resetl,
  add_sat_pipe_if.slave bus,
  input  logic         clr,
`ifdef ADD_SAT_PIPE_STICKY_EN
  output logic [WIDTH/8-1:0] sat_sticky,
`endif
  output logic [15:0]  sat_cnt
);

  localparam int NSEG = WIDTH / 8;

  logic             adv1;
  logic             adv2;

  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic             s1_sat;
  logic [WIDTH-1:0] s1_sum;
  logic [NSEG-1:0]  s1_cy;
  logic [NSEG-1:0]  s1_bsign;

  logic             out_valid;
  logic [WIDTH-1:0] r;
  logic             co;
  logic [NSEG-1:0]  satf;

  logic [NSEG:0]    chain;
  logic [NSEG-1:0]  seg_cin;
  logic [WIDTH-1:0] seg_sum;
  logic [NSEG-1:0]  bsign_seg;
  logic [WIDTH-1:0] nxt_r;
  logic [NSEG-1:0]  nxt_satf;
  logic             out_xfer;

  assign adv2          = !out_valid | bus.out_ready;
  assign adv1          = !s1_valid | adv2;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid;
  assign bus.r         = r;
  assign bus.co        = co;
  assign bus.satf      = satf;
  assign out_xfer      = out_valid & bus.out_ready;

  // chain[k] is the carry out of segment k-1; lane boundaries restart from cin.
  always_comb begin
    chain   = '0;
    seg_cin = '0;
    seg_sum = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0 || bus.mode == 2'd0 || (bus.mode == 2'd1 && (k % 2) == 0))
        seg_cin[k] = bus.cin;
      else
        seg_cin[k] = chain[k];
      {chain[k+1], seg_sum[8*k +: 8]} = {1'b0, bus.a[8*k +: 8]}
                                      + {1'b0, bus.b[8*k +: 8]}
                                      + {8'd0, seg_cin[k]};
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int PAIR_TOP = k | 1;
    logic lane_cy;
    logic lane_bs;
    logic clamp;

    assign bsign_seg[k] = bus.b[8*k + 7];

    // Each segment looks at the carry/sign of the top segment of its lane.
    always_comb begin
      lane_cy = s1_cy[NSEG-1];
      lane_bs = s1_bsign[NSEG-1];
      case (s1_mode)
        2'd0: begin
          lane_cy = s1_cy[k];
          lane_bs = s1_bsign[k];
        end
        2'd1: begin
          lane_cy = s1_cy[PAIR_TOP];
          lane_bs = s1_bsign[PAIR_TOP];
        end
        default: ;
      endcase
    end

    assign clamp             = s1_sat & (lane_cy ^ lane_bs);
    assign nxt_satf[k]       = clamp;
    assign nxt_r[8*k +: 8]   = clamp ? {8{lane_cy}} : s1_sum[8*k +: 8];
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'd0;
      s1_sat   <= 1'b0;
      s1_sum   <= '0;
      s1_cy    <= '0;
      s1_bsign <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode  <= bus.mode;
        s1_sat   <= bus.sat;
        s1_sum   <= seg_sum;
        s1_cy    <= chain[NSEG:1];
        s1_bsign <= bsign_seg;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      out_valid <= 1'b0;
      r         <= '0;
      co        <= 1'b0;
      satf      <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        r    <= nxt_r;
        co   <= s1_cy[NSEG-1];
        satf <= nxt_satf;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)
      sat_cnt <= 16'd0;
    else if (clr)
      sat_cnt <= 16'd0;
    else if (out_xfer && (|satf) && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end

`ifdef ADD_SAT_PIPE_STICKY_EN
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)
      sat_sticky <= '0;
    else if (clr)
      sat_sticky <= '0;
    else if (out_xfer)
      sat_sticky <= sat_sticky | satf;
  end
`endif

endmodule

`default_nettype wire
